// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//   Shares one ALU between two requesters (0 = pipeline execute,
//   1 = branch/address unit). A round-robin choice picks the winner in IDLE.
//   The winner's operands are registered onto the ALU inputs, held for
//   ALU_LAT clocks, and the ALU result is then captured. The captured result
//   is returned to the winner only, with a valid/ready handshake.
//
// Ports
//   clk, reset         clock (posedge) and asynchronous active-low reset
//   req_valid/ready    per-requester request handshake (ready is combinational)
//   req_*              packed request fields, requester 1 in the upper slice
//   resp_valid/ready   per-requester response handshake
//   resp_out/branch    captured ALU result on a bus shared by both requesters
//   flush              synchronous abort of the in-flight op / pending result
//   alu_*              registered operand bus to the ALU, and its result inputs
// -----------------------------------------------------------------------------
module alu_arbiter #(
  parameter int         WORD_SIZE = 32,
  parameter int         ALU_LAT   = 1,
  parameter logic [4:0] IDLE_CTRL = 5'h1F
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [9:0]             req_control,
  input  logic [2*WORD_SIZE-1:0] req_in_1,
  input  logic [2*WORD_SIZE-1:0] req_in_2,
  input  logic [2*WORD_SIZE-1:0] req_pc,
  input  logic [23:0]            req_imm,
  input  logic [39:0]            req_imm_U_J,
  input  logic [3:0]             req_imm_en,
  output logic [1:0]             resp_valid,
  input  logic [1:0]             resp_ready,
  output logic [WORD_SIZE-1:0]   resp_out,
  output logic                   resp_branch,
  input  logic                   flush,
  output logic [4:0]             alu_control,
  output logic [1:0]             alu_imm_en,
  output logic [11:0]            alu_imm,
  output logic [19:0]            alu_imm_U_J,
  output logic [WORD_SIZE-1:0]   alu_in_1,
  output logic [WORD_SIZE-1:0]   alu_in_2,
  output logic [WORD_SIZE-1:0]   alu_pc,
  input  logic [WORD_SIZE-1:0]   alu_out,
  input  logic                   alu_take_branch
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [2:0] LAT_INIT = 3'(ALU_LAT);

  state_t               state_q, state_d;
  logic                 rr_ptr_q, rr_ptr_d;
  logic                 owner_q, owner_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [WORD_SIZE-1:0] resp_out_q, resp_out_d;
  logic                 resp_branch_q, resp_branch_d;
  logic [4:0]           alu_control_q, alu_control_d;
  logic [1:0]           alu_imm_en_q, alu_imm_en_d;
  logic [11:0]          alu_imm_q, alu_imm_d;
  logic [19:0]          alu_imm_U_J_q, alu_imm_U_J_d;
  logic [WORD_SIZE-1:0] alu_in_1_q, alu_in_1_d;
  logic [WORD_SIZE-1:0] alu_in_2_q, alu_in_2_d;
  logic [WORD_SIZE-1:0] alu_pc_q, alu_pc_d;

  // Per-requester views of the packed request fields.
  logic [4:0]           ctl_a    [2];
  logic [WORD_SIZE-1:0] in1_a    [2];
  logic [WORD_SIZE-1:0] in2_a    [2];
  logic [WORD_SIZE-1:0] pc_a     [2];
  logic [11:0]          imm_a    [2];
  logic [19:0]          imm_uj_a [2];
  logic [1:0]           imm_en_a [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
    assign ctl_a[gi]    = req_control[gi*5 +: 5];
    assign in1_a[gi]    = req_in_1[gi*WORD_SIZE +: WORD_SIZE];
    assign in2_a[gi]    = req_in_2[gi*WORD_SIZE +: WORD_SIZE];
    assign pc_a[gi]     = req_pc[gi*WORD_SIZE +: WORD_SIZE];
    assign imm_a[gi]    = req_imm[gi*12 +: 12];
    assign imm_uj_a[gi] = req_imm_U_J[gi*20 +: 20];
    assign imm_en_a[gi] = req_imm_en[gi*2 +: 2];
  end

  logic grant;
  logic accept;

  // A lone requester always wins; on contention the round-robin pointer decides.
  always_comb begin
    grant = req_valid[1];
    if (&req_valid) begin
      grant = rr_ptr_q;
    end
  end

  assign accept     = (state_q == ST_IDLE) && !flush && (|req_valid);
  assign req_ready  = accept ? (grant ? 2'b10 : 2'b01) : 2'b00;
  assign resp_valid = (state_q == ST_RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    owner_d       = owner_q;
    cnt_d         = cnt_q;
    resp_out_d    = resp_out_q;
    resp_branch_d = resp_branch_q;
    alu_control_d = alu_control_q;
    alu_imm_en_d  = alu_imm_en_q;
    alu_imm_d     = alu_imm_q;
    alu_imm_U_J_d = alu_imm_U_J_q;
    alu_in_1_d    = alu_in_1_q;
    alu_in_2_d    = alu_in_2_q;
    alu_pc_d      = alu_pc_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          alu_control_d = ctl_a[grant];
          alu_imm_en_d  = imm_en_a[grant];
          alu_imm_d     = imm_a[grant];
          alu_imm_U_J_d = imm_uj_a[grant];
          alu_in_1_d    = in1_a[grant];
          alu_in_2_d    = in2_a[grant];
          alu_pc_d      = pc_a[grant];
          owner_d       = grant;
          cnt_d         = LAT_INIT;
          state_d       = ST_BUSY;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - 3'd1;
        // The ALU evaluates on the negedge, so its output is settled by the
        // posedge on which the countdown reaches one.
        if (cnt_q == 3'd1) begin
          resp_out_d    = alu_out;
          resp_branch_d = alu_take_branch;
          alu_control_d = IDLE_CTRL;
          state_d       = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready[owner_q]) begin
          rr_ptr_d = ~owner_q;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Flush overrides everything; the pointer is left alone so the aborted
    // requester keeps its turn.
    if (flush && (state_q != ST_IDLE)) begin
      state_d       = ST_IDLE;
      rr_ptr_d      = rr_ptr_q;
      cnt_d         = cnt_q;
      resp_out_d    = resp_out_q;
      resp_branch_d = resp_branch_q;
      alu_control_d = IDLE_CTRL;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      rr_ptr_q      <= 1'b0;
      owner_q       <= 1'b0;
      cnt_q         <= 3'd0;
      resp_out_q    <= '0;
      resp_branch_q <= 1'b0;
      alu_control_q <= IDLE_CTRL;
      alu_imm_en_q  <= 2'b00;
      alu_imm_q     <= 12'h000;
      alu_imm_U_J_q <= 20'h00000;
      alu_in_1_q    <= '0;
      alu_in_2_q    <= '0;
      alu_pc_q      <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      owner_q       <= owner_d;
      cnt_q         <= cnt_d;
      resp_out_q    <= resp_out_d;
      resp_branch_q <= resp_branch_d;
      alu_control_q <= alu_control_d;
      alu_imm_en_q  <= alu_imm_en_d;
      alu_imm_q     <= alu_imm_d;
      alu_imm_U_J_q <= alu_imm_U_J_d;
      alu_in_1_q    <= alu_in_1_d;
      alu_in_2_q    <= alu_in_2_d;
      alu_pc_q      <= alu_pc_d;
    end
  end

  assign resp_out    = resp_out_q;
  assign resp_branch = resp_branch_q;
  assign alu_control = alu_control_q;
  assign alu_imm_en  = alu_imm_en_q;
  assign alu_imm     = alu_imm_q;
  assign alu_imm_U_J = alu_imm_U_J_q;
  assign alu_in_1    = alu_in_1_q;
  assign alu_in_2    = alu_in_2_q;
  assign alu_pc      = alu_pc_q;

endmodule
